// File: rtl/dly_meas_pkg.sv
// Shared types and helpers for the delay-line frequency measurement controller.
package dly_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    REPORT  = 2'd3
  } state_e;

  function automatic int tap_w(input int n_taps);
    return (n_taps < 2) ? 1 : $clog2(n_taps);
  endfunction

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dly_line_meas_ctrl_if.sv
// Result channel from the measurement controller to the calibration engine (valid/ready).
interface dly_line_meas_ctrl_if #(
  parameter int TAP_W = 3,
  parameter int CNT_W = 16
);
  logic             res_valid;
  logic             res_ready;
  logic [TAP_W-1:0] res_tap;
  logic [CNT_W-1:0] res_count;

  modport master (output res_valid, output res_tap, output res_count, input res_ready);
  modport slave  (input res_valid, input res_tap, input res_count, output res_ready);
endinterface

// File: rtl/sat_edge_cnt.sv
// Oscillator edge detector plus clearable saturating counter; cnt_nxt includes this cycle's edge.
module sat_edge_cnt
  import dly_meas_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             osc_tog,
  output logic [CNT_W-1:0] cnt_nxt
);

  localparam logic [CNT_W-1:0] ONES = '1;

  logic             osc_tog_q;
  logic [CNT_W-1:0] count;
  logic [31:0]      inc;

  always_comb begin
    inc     = sat_inc(32'(count), 32'(ONES));
    cnt_nxt = count;
    if (clr) begin
      cnt_nxt = '0;
    end else if (en && (osc_tog ^ osc_tog_q)) begin
      cnt_nxt = inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    osc_tog_q <= osc_tog;
    count     <= cnt_nxt;
  end

endmodule

// File: rtl/dly_line_meas_ctrl.sv
// Tap-sweep frequency measurement sequencer for the tapped ring-oscillator delay line.
// Optional min/max tracking over the sweep is enabled by defining DLY_MEAS_MINMAX_EN.
module dly_line_meas_ctrl
  import dly_meas_pkg::*;
#(
  parameter  int N_TAPS     = 8,
  parameter  int CNT_W      = 16,
  parameter  int WIN_W      = 12,
  parameter  int SETTLE_CYC = 4,
  localparam int TAP_W      = tap_w(N_TAPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIN_W-1:0]     win_len,
  input  logic                 osc_tog,
  output logic                 osc_en,
  output logic [TAP_W-1:0]     tap_sel,
  output logic                 busy,
  output logic                 done,
  dly_line_meas_ctrl_if.master res,
  output logic [CNT_W-1:0]     min_cnt,
  output logic [CNT_W-1:0]     max_cnt,
  output logic [TAP_W-1:0]     min_tap,
  output logic [TAP_W-1:0]     max_tap
);

  localparam int TMR_W = (WIN_W > $clog2(SETTLE_CYC) + 1) ? WIN_W : $clog2(SETTLE_CYC) + 1;
  localparam logic [TAP_W-1:0] LAST_TAP  = TAP_W'(N_TAPS - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);

  state_e           state;
  logic [TMR_W-1:0] tmr;
  logic [WIN_W-1:0] win_m1;
  logic             res_valid;
  logic [TAP_W-1:0] res_tap;
  logic [CNT_W-1:0] res_count;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_clr;
  logic             cnt_en;
  logic             start_ok;
  logic             handshake;

  assign cnt_clr   = (state == SETTLE);
  assign cnt_en    = (state == MEASURE);
  assign start_ok  = (state == IDLE) && start && !abort;
  assign handshake = (state == REPORT) && res_valid && res.res_ready && !abort;

  assign res.res_valid = res_valid;
  assign res.res_tap   = res_tap;
  assign res.res_count = res_count;

  sat_edge_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .osc_tog (osc_tog),
    .cnt_nxt (cnt_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tmr       <= '0;
      win_m1    <= '0;
      osc_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tap_sel   <= '0;
      res_valid <= 1'b0;
      res_tap   <= '0;
      res_count <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state     <= IDLE;
        osc_en    <= 1'b0;
        busy      <= 1'b0;
        tap_sel   <= '0;
        res_valid <= 1'b0;
        res_tap   <= '0;
        res_count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              state   <= SETTLE;
              tap_sel <= '0;
              osc_en  <= 1'b1;
              busy    <= 1'b1;
              tmr     <= SETTLE_LD;
              // A zero window still measures for one cycle.
              win_m1  <= (win_len == '0) ? '0 : win_len - 1'b1;
            end
          end
          SETTLE: begin
            if (tmr == '0) begin
              state <= MEASURE;
              tmr   <= TMR_W'(win_m1);
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          MEASURE: begin
            if (tmr == '0) begin
              state     <= REPORT;
              res_valid <= 1'b1;
              res_tap   <= tap_sel;
              res_count <= cnt_nxt;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          REPORT: begin
            if (res.res_ready) begin
              res_valid <= 1'b0;
              if (tap_sel == LAST_TAP) begin
                state  <= IDLE;
                osc_en <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else begin
                state   <= SETTLE;
                tap_sel <= tap_sel + 1'b1;
                tmr     <= SETTLE_LD;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef DLY_MEAS_MINMAX_EN
  // First result of a sweep seeds both extremes; strict compares keep the lower tap on ties.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      min_cnt <= '0;
      max_cnt <= '0;
      min_tap <= '0;
      max_tap <= '0;
    end else if (handshake) begin
      if ((res_tap == '0) || (res_count < min_cnt)) begin
        min_cnt <= res_count;
        min_tap <= res_tap;
      end
      if ((res_tap == '0) || (res_count > max_cnt)) begin
        max_cnt <= res_count;
        max_tap <= res_tap;
      end
    end
  end
`else
  assign min_cnt = '0;
  assign max_cnt = '0;
  assign min_tap = '0;
  assign max_tap = '0;
  logic unused_hs;
  assign unused_hs = handshake;
`endif

endmodule

// File: tb/tb_dly_line_meas_ctrl.sv
// Randomised self-checking bench for dly_line_meas_ctrl; reference model works from the osc_tog history.
`timescale 1ns/1ps
module tb_dly_line_meas_ctrl;

  localparam int N_TAPS     = 8;
  localparam int CNT_W      = 8;
  localparam int WIN_W      = 12;
  localparam int SETTLE_CYC = 4;
  localparam int TAP_W      = 3;
  localparam int CMAX       = (1 << CNT_W) - 1;
  localparam int HMAX       = 32768;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic             osc_tog;
  logic             osc_en, busy, done;
  logic [TAP_W-1:0] tap_sel, min_tap, max_tap;
  logic [CNT_W-1:0] min_cnt, max_cnt;

  dly_line_meas_ctrl_if #(.TAP_W(TAP_W), .CNT_W(CNT_W)) rif ();

  dly_line_meas_ctrl #(
    .N_TAPS(N_TAPS), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .win_len(win_len),
    .osc_tog(osc_tog), .osc_en(osc_en), .tap_sel(tap_sel), .busy(busy), .done(done),
    .res(rif), .min_cnt(min_cnt), .max_cnt(max_cnt), .min_tap(min_tap), .max_tap(max_tap)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit hist [0:HMAX-1];
  int osc_mode = 0;
  bit ph = 1'b0;

  int r_cnt [0:N_TAPS-1];
  int last_start_edge, last_done_edge;
  int m_min, m_max, m_mint, m_maxt;
  bit m_any;

  always @(posedge clk) begin
    if (cyc < HMAX) hist[cyc] <= osc_tog;
    cyc <= cyc + 1;
  end

  // osc_tog patterns: 0 hold, 1 toggle every cycle, 2 toggle every 2 cycles, 3 random.
  initial begin
    osc_tog = 1'b0;
    forever begin
      @(negedge clk);
      case (osc_mode)
        1: osc_tog = ~osc_tog;
        2: begin ph = ~ph; if (ph) osc_tog = ~osc_tog; end
        3: osc_tog = osc_tog ^ 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time exceeded, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic int model_cnt(input int rise, input int w);
    int s;
    s = 0;
    for (int j = rise - w + 1; j <= rise; j++) s += int'(hist[j] ^ hist[j-1]);
    return (s > CMAX) ? CMAX : s;
  endfunction

  task automatic check_extremes(input string tag);
    int e_min, e_max, e_mint, e_maxt;
`ifdef DLY_MEAS_MINMAX_EN
    e_min = m_min; e_max = m_max; e_mint = m_mint; e_maxt = m_maxt;
`else
    e_min = 0; e_max = 0; e_mint = 0; e_maxt = 0;
`endif
    n_cmp++;
    if (int'(min_cnt) !== e_min || int'(min_tap) !== e_mint) begin
      n_bad++;
      $display("FAIL %s_min: got cnt %0d tap %0d want cnt %0d tap %0d", tag, min_cnt, min_tap, e_min, e_mint);
    end
    n_cmp++;
    if (int'(max_cnt) !== e_max || int'(max_tap) !== e_maxt) begin
      n_bad++;
      $display("FAIL %s_max: got cnt %0d tap %0d want cnt %0d tap %0d", tag, max_cnt, max_tap, e_max, e_maxt);
    end
  endtask

  // Runs one sweep; per-tap timing follows SETTLE_CYC + W + 1 from each handshake.
  task automatic do_sweep(input logic [WIN_W-1:0] wl, input int stall_tap, input int stall_len,
                          input int abort_tap, input int spur_tap, input string tag);
    int  w, seg, exp_rise, exp_cnt, mid;
    bit  early, held_ok, quiet;
    logic [TAP_W-1:0] tap0;
    logic [CNT_W-1:0] cnt0;
    w = (wl == '0) ? 1 : int'(wl);
    @(posedge clk); #1;
    rif.res_ready = 1'b1;
    win_len = wl;
    start = 1'b1;
    seg = cyc;
    last_start_edge = seg;
    m_any = 0; m_min = 0; m_max = 0; m_mint = 0; m_maxt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    win_len = WIN_W'($urandom);
    for (int k = 0; k < N_TAPS; k++) begin
      exp_rise = seg + SETTLE_CYC + w;
      if (k == stall_tap) rif.res_ready = 1'b0;
      if (k == spur_tap) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (k == abort_tap) begin
        mid = seg + SETTLE_CYC + (w - 1) / 2;
        while (cyc - 1 < mid) begin @(posedge clk); #1; end
        abort = 1'b1;
        rif.res_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_cmp++;
        if ({osc_en, busy, done, rif.res_valid} !== 4'b0000 || tap_sel !== '0 || rif.res_count !== '0) begin
          n_bad++;
          $display("FAIL %s_abort_idle: got en/busy/done/vld=%b tap=%0d cnt=%0d want 0000/0/0",
                   tag, {osc_en, busy, done, rif.res_valid}, tap_sel, rif.res_count);
        end
        check_extremes({tag, "_abort"});
        quiet = 1;
        repeat (SETTLE_CYC + w + 4) begin
          @(posedge clk); #1;
          if (done || busy || osc_en || rif.res_valid) quiet = 0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin
          n_bad++;
          $display("FAIL %s_abort_quiet: got activity after abort want none", tag);
        end
        return;
      end
      early = 0;
      while (cyc - 1 < exp_rise) begin
        if (rif.res_valid === 1'b1) early = 1;
        @(posedge clk); #1;
      end
      n_cmp++;
      if (rif.res_valid !== 1'b1 || early) begin
        n_bad++;
        $display("FAIL %s_valid_t%0d: got valid=%b early=%0d want valid=1 at edge %0d", tag, k, rif.res_valid, early, exp_rise);
      end
      n_cmp++;
      if (int'(rif.res_tap) !== k || int'(tap_sel) !== k) begin
        n_bad++;
        $display("FAIL %s_tap: got res_tap=%0d tap_sel=%0d want %0d", tag, rif.res_tap, tap_sel, k);
      end
      exp_cnt = model_cnt(exp_rise, w);
      r_cnt[k] = int'(rif.res_count);
      n_cmp++;
      if (int'(rif.res_count) !== exp_cnt) begin
        n_bad++;
        $display("FAIL %s_count_t%0d: got %0d want %0d", tag, k, rif.res_count, exp_cnt);
      end
      if (k == stall_tap) begin
        tap0 = rif.res_tap; cnt0 = rif.res_count; held_ok = 1;
        repeat (stall_len) begin
          @(posedge clk); #1;
          if (rif.res_valid !== 1'b1 || rif.res_tap !== tap0 || rif.res_count !== cnt0) held_ok = 0;
        end
        n_cmp++;
        if (held_ok !== 1'b1) begin
          n_bad++;
          $display("FAIL %s_stall_hold: got valid=%b tap=%0d cnt=%0d want 1/%0d/%0d stable",
                   tag, rif.res_valid, rif.res_tap, rif.res_count, tap0, cnt0);
        end
        rif.res_ready = 1'b1;
      end
      seg = cyc;
      if (!m_any) begin
        m_any = 1; m_min = exp_cnt; m_max = exp_cnt; m_mint = k; m_maxt = k;
      end else begin
        if (exp_cnt < m_min) begin m_min = exp_cnt; m_mint = k; end
        if (exp_cnt > m_max) begin m_max = exp_cnt; m_maxt = k; end
      end
      @(posedge clk); #1;
      if (k == N_TAPS - 1) begin
        last_done_edge = cyc - 1;
        n_cmp++;
        if ({done, busy, osc_en, rif.res_valid} !== 4'b1000) begin
          n_bad++;
          $display("FAIL %s_done: got done/busy/en/vld=%b want 1000", tag, {done, busy, osc_en, rif.res_valid});
        end
        check_extremes(tag);
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_done_pulse: got done=%b busy=%b want 0 0", tag, done, busy);
        end
      end else begin
        n_cmp++;
        if (rif.res_valid !== 1'b0 || busy !== 1'b1 || osc_en !== 1'b1) begin
          n_bad++;
          $display("FAIL %s_after_hs: got vld=%b busy=%b en=%b want 0 1 1", tag, rif.res_valid, busy, osc_en);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rif.res_ready = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({osc_en, busy, done, rif.res_valid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got en/busy/done/vld=%b want 0000", {osc_en, busy, done, rif.res_valid});
    end
    n_cmp++;
    if (tap_sel !== '0 || rif.res_tap !== '0 || rif.res_count !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got tap_sel=%0d res_tap=%0d res_count=%0d want 0 0 0", tap_sel, rif.res_tap, rif.res_count);
    end
    n_cmp++;
    if (min_cnt !== '0 || max_cnt !== '0 || min_tap !== '0 || max_tap !== '0) begin
      n_bad++;
      $display("FAIL reset_ext: got %0d %0d %0d %0d want 0", min_cnt, max_cnt, min_tap, max_tap);
    end
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bool_chk: begin end
    osc_mode = 2;
    do_sweep(12'd100, -1, 0, -1, -1, "basic");
    for (int k = 0; k < N_TAPS; k++) begin
      n_cmp++;
      if (r_cnt[k] !== 50) begin
        n_bad++;
        $display("FAIL basic_50_t%0d: got %0d want 50", k, r_cnt[k]);
      end
    end
    n_cmp++;
    if (last_done_edge - last_start_edge !== 840) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d want 840", last_done_edge - last_start_edge);
    end
  endtask

  task automatic test_backpressure();
    osc_mode = 3;
    do_sweep(12'd30, 3, 20, -1, 1, "stall");
  endtask

  task automatic test_saturation();
    osc_mode = 1;
    do_sweep(12'd300, -1, 0, -1, -1, "sat");
    n_cmp++;
    if (r_cnt[0] !== CMAX || r_cnt[N_TAPS-1] !== CMAX) begin
      n_bad++;
      $display("FAIL sat_value: got %0d/%0d want %0d", r_cnt[0], r_cnt[N_TAPS-1], CMAX);
    end
  endtask

  task automatic test_abort();
    osc_mode = 3;
    do_sweep(12'd50, -1, 0, 2, -1, "abort");
  endtask

  task automatic test_idle_start_abort();
    bit stayed;
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    stayed = 1;
    repeat (6) begin
      if (busy || osc_en || rif.res_valid || done) stayed = 0;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (stayed !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_start_abort: got busy=%b en=%b want idle", busy, osc_en);
    end
  endtask

  task automatic test_win0();
    osc_mode = 3;
    do_sweep(12'd0, -1, 0, -1, -1, "win0");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      osc_mode = 3;
      do_sweep((i == 3) ? WIN_W'($urandom_range(1, 4)) : WIN_W'($urandom_range(1, 80)),
               $urandom_range(0, N_TAPS - 1), $urandom_range(1, 12), -1, -1, "rand");
    end
  endtask

  initial begin
    rif.res_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_abort();
    test_idle_start_abort();
    test_win0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
